// File: rtl/qpsk_tx_shaper.sv
// Two-channel (I/Q) polyphase pulse-shaping transmit filter: upsamples QPSK symbols by OS
// through a shared symmetric FIR. Optional runtime coefficient load: QPSK_TX_COEF_LOAD_EN.
module qpsk_tx_shaper #(
    parameter int OS   = 4,
    parameter int NSYM = 6,
    parameter int CW   = 8,
    parameter int OW   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_en,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [1:0]                    s_sym,
`ifdef QPSK_TX_COEF_LOAD_EN
    input  logic                          coef_we,
    input  logic [$clog2(OS*NSYM)-1:0]    coef_addr,
    input  logic signed [CW-1:0]          coef_data,
`endif
    output logic                          o_valid,
    output logic signed [OW-1:0]          o_i,
    output logic signed [OW-1:0]          o_q,
    output logic [$clog2(OS)-1:0]         o_phase,
    output logic                          o_underrun
);

    localparam int TAPS = OS * NSYM;
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = $clog2(OS);
    localparam int SW   = CW + $clog2(NSYM) + 1;
    localparam int XW   = (OW > SW) ? OW + 1 : SW + 1;

    function automatic logic signed [CW-1:0] default_coef(input int k);
        logic signed [7:0] v;
        case (k)
            0:  v = 8'sh00;  1:  v = 8'shFE;  2:  v = 8'shFF;  3:  v = 8'sh00;
            4:  v = 8'sh02;  5:  v = 8'sh00;  6:  v = 8'shFB;  7:  v = 8'shF5;
            8:  v = 8'shF9;  9:  v = 8'sh0A;  10: v = 8'sh25;  11: v = 8'sh3E;
            12: v = 8'sh48;  13: v = 8'sh3E;  14: v = 8'sh25;  15: v = 8'sh0A;
            16: v = 8'shF9;  17: v = 8'shF5;  18: v = 8'shFB;  19: v = 8'sh00;
            20: v = 8'sh02;  21: v = 8'sh00;  22: v = 8'shFF;  23: v = 8'shFE;
            default: v = 8'sh00;
        endcase
        return CW'(v);
    endfunction

    // Clamp to the OW signed range; evaluated in a width wide enough for both sides.
    function automatic logic signed [OW-1:0] saturate(input logic signed [SW-1:0] v);
        logic signed [XW-1:0] vx;
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        vx = XW'(v);
        hi = $signed({{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}});
        lo = ~hi;
        if (vx > hi) begin
            return OW'(hi);
        end else if (vx < lo) begin
            return OW'(lo);
        end
        return OW'(vx);
    endfunction

    logic signed [CW-1:0] coef_c [TAPS];

    for (genvar k = 0; k < TAPS; k++) begin : g_coef
`ifdef QPSK_TX_COEF_LOAD_EN
        // Not reset: power-up value is the default table, later writes persist across reset.
        logic signed [CW-1:0] coef_q = default_coef(k);
        logic signed [CW-1:0] coef_d;

        always_comb begin
            coef_d = coef_q;
            if (coef_we && (coef_addr == AW'(k))) begin
                coef_d = coef_data;
            end
        end

        always_ff @(posedge clk) begin
            coef_q <= coef_d;
        end

        assign coef_c[k] = coef_q;
`else
        assign coef_c[k] = default_coef(k);
`endif
    end

    logic [PW-1:0]          phase_q,      phase_d;
    logic [NSYM-1:0]        live_q,       live_d;
    logic [NSYM-1:0]        isgn_q,       isgn_d;
    logic [NSYM-1:0]        qsgn_q,       qsgn_d;
    logic                   started_q,    started_d;
    logic                   o_valid_q,    o_valid_d;
    logic signed [OW-1:0]   o_i_q,        o_i_d;
    logic signed [OW-1:0]   o_q_q,        o_q_d;
    logic [PW-1:0]          o_phase_q,    o_phase_d;
    logic                   o_underrun_q, o_underrun_d;

    logic signed [SW-1:0]   sum_i;
    logic signed [SW-1:0]   sum_q;
    logic                   accept;

    // Gated by reset so upstream never sees a handshake that the reset discards.
    assign accept  = i_en & ~reset & (phase_q == PW'(OS - 1));
    assign s_ready = accept;

    always_comb begin
        logic signed [SW-1:0] term;
        sum_i = '0;
        sum_q = '0;
        term  = '0;
        for (int j = 0; j < NSYM; j++) begin
            term = SW'(coef_c[AW'(j * OS) + AW'(phase_q)]);
            if (live_q[j]) begin
                sum_i = isgn_q[j] ? sum_i + term : sum_i - term;
                sum_q = qsgn_q[j] ? sum_q + term : sum_q - term;
            end
        end
    end

    always_comb begin
        phase_d      = phase_q;
        live_d       = live_q;
        isgn_d       = isgn_q;
        qsgn_d       = qsgn_q;
        started_d    = started_q;
        o_valid_d    = i_en;
        o_i_d        = o_i_q;
        o_q_d        = o_q_q;
        o_phase_d    = o_phase_q;
        o_underrun_d = o_underrun_q;
        if (i_en) begin
            o_i_d     = saturate(sum_i);
            o_q_d     = saturate(sum_q);
            o_phase_d = phase_q;
            phase_d   = phase_q + PW'(1);
            if (accept) begin
                live_d = {s_valid,  live_q[NSYM-1:1]};
                isgn_d = {s_sym[1], isgn_q[NSYM-1:1]};
                qsgn_d = {s_sym[0], qsgn_q[NSYM-1:1]};
                if (s_valid) begin
                    started_d = 1'b1;
                end else if (started_q) begin
                    o_underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            live_q       <= '0;
            isgn_q       <= '0;
            qsgn_q       <= '0;
            started_q    <= 1'b0;
            o_valid_q    <= 1'b0;
            o_i_q        <= '0;
            o_q_q        <= '0;
            o_phase_q    <= '0;
            o_underrun_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            live_q       <= live_d;
            isgn_q       <= isgn_d;
            qsgn_q       <= qsgn_d;
            started_q    <= started_d;
            o_valid_q    <= o_valid_d;
            o_i_q        <= o_i_d;
            o_q_q        <= o_q_d;
            o_phase_q    <= o_phase_d;
            o_underrun_q <= o_underrun_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_i        = o_i_q;
    assign o_q        = o_q_q;
    assign o_phase    = o_phase_q;
    assign o_underrun = o_underrun_q;

endmodule

// File: tb/tb_qpsk_tx_shaper.sv
// Bench for qpsk_tx_shaper: impulse tables, hand sequences and a random stream checked
// against a symbol-history reference model. Builds the coefficient-load test with QPSK_TX_COEF_LOAD_EN.
module tb_qpsk_tx_shaper;

    localparam int OS   = 4;
    localparam int NSYM = 6;
    localparam int CW   = 8;
`ifdef QPSK_TX_COEF_LOAD_EN
    localparam int OW   = 8;
`else
    localparam int OW   = 16;
`endif
    localparam int TAPS = OS * NSYM;
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = $clog2(OS);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 i_en;
    logic                 s_valid;
    logic                 s_ready;
    logic [1:0]           s_sym;
    logic                 o_valid;
    logic signed [OW-1:0] o_i;
    logic signed [OW-1:0] o_q;
    logic [PW-1:0]        o_phase;
    logic                 o_underrun;
`ifdef QPSK_TX_COEF_LOAD_EN
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
`endif

    qpsk_tx_shaper #(.OS(OS), .NSYM(NSYM), .CW(CW), .OW(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sym      (s_sym),
`ifdef QPSK_TX_COEF_LOAD_EN
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
`endif
        .o_valid    (o_valid),
        .o_i        (o_i),
        .o_q        (o_q),
        .o_phase    (o_phase),
        .o_underrun (o_underrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference coefficients (decimal form of the published hex table).
    int c_ref [TAPS] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                         72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
    int imp [24] = '{2, 0, -1, -2, -7, -11, -5, 0, 72, 62, 37, 10,
                     -7, 10, 37, 62, 2, 0, -5, -11, 0, -2, -1, 0};

    // Model state: enabled-sample phase and the history of symbol values (+1/-1/0).
    int m_phase;
    int hist_i [$];
    int hist_q [$];
    bit m_started;
    bit m_under;
    int e_i, e_q, e_ph;
    bit e_v;

    typedef struct {
        bit         vld;
        logic [1:0] sym;
        int         exp_i;
        int         exp_q;
        bit         exp_u;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat(input int v);
        int hi;
        int lo;
        hi = (1 << (OW - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic step(input bit rst, input bit en, input bit vld, input logic [1:0] sym,
                        input bit we, input int waddr, input int wdata);
        int si;
        int sq;
        int h;
        reset   = rst;
        i_en    = en;
        s_valid = vld;
        s_sym   = sym;
`ifdef QPSK_TX_COEF_LOAD_EN
        coef_we   = we;
        coef_addr = AW'(waddr);
        coef_data = CW'(wdata);
`endif
        #1;
        chk("s_ready", int'(s_ready), int'(!rst && en && (m_phase == OS - 1)));
        if (rst) begin
            m_phase = 0;
            hist_i.delete();
            hist_q.delete();
            m_started = 0;
            m_under = 0;
            e_i = 0; e_q = 0; e_v = 0; e_ph = 0;
        end else if (en) begin
            si = 0;
            sq = 0;
            for (int j = 0; j < NSYM; j++) begin
                h = hist_i.size() - NSYM + j;
                if (h >= 0) begin
                    si += c_ref[j * OS + m_phase] * hist_i[h];
                    sq += c_ref[j * OS + m_phase] * hist_q[h];
                end
            end
            e_i = sat(si);
            e_q = sat(sq);
            e_v = 1;
            e_ph = m_phase;
            if (m_phase == OS - 1) begin
                if (vld) begin
                    hist_i.push_back(sym[1] ? 1 : -1);
                    hist_q.push_back(sym[0] ? 1 : -1);
                    m_started = 1;
                end else begin
                    hist_i.push_back(0);
                    hist_q.push_back(0);
                    if (m_started) m_under = 1;
                end
            end
            m_phase = (m_phase + 1) % OS;
        end else begin
            e_v = 0;
        end
        if (we && waddr >= 0 && waddr < TAPS) c_ref[waddr] = wdata;
        @(posedge clk);
        @(negedge clk);
        chk("o_valid", int'(o_valid), int'(e_v));
        chk("o_i", $signed(o_i), e_i);
        chk("o_q", $signed(o_q), e_q);
        chk("o_phase", int'(o_phase), e_ph);
        chk("o_underrun", int'(o_underrun), int'(m_under));
    endtask

    task automatic fill_table(input logic [1:0] sym, input bit neg_q);
        for (int k = 0; k < 32; k++) begin
            tbl[k].vld   = (k == 3);
            tbl[k].sym   = (k == 3) ? sym : 2'b00;
            tbl[k].exp_i = (k >= 4 && k < 28) ? imp[k - 4] : 0;
            tbl[k].exp_q = neg_q ? -tbl[k].exp_i : tbl[k].exp_i;
            tbl[k].exp_u = (k >= 7);
        end
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 32; k++) begin
            step(0, 1, tbl[k].vld, tbl[k].sym, 0, 0, 0);
            chk({tag, "_i"}, $signed(o_i), tbl[k].exp_i);
            chk({tag, "_q"}, $signed(o_q), tbl[k].exp_q);
            chk({tag, "_underrun"}, int'(o_underrun), int'(tbl[k].exp_u));
        end
    endtask

    initial begin
        int we, wa, wd;
        m_phase = 0;
        m_started = 0;
        m_under = 0;
        e_i = 0; e_q = 0; e_v = 0; e_ph = 0;

        // Reset state
        step(1, 1, 0, 2'b00, 0, 0, 0);
        chk("reset_o_i", $signed(o_i), 0);
        chk("reset_o_valid", int'(o_valid), 0);

        // Impulse and polarity
        fill_table(2'b11, 0);
        run_table("impulse");
        step(1, 0, 0, 2'b00, 0, 0, 0);
        fill_table(2'b10, 1);
        run_table("polarity");

        // Steady stream of +1/+1
        step(1, 0, 0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 48; k++) begin
            step(0, 1, 1, 2'b11, 0, 0, 0);
            if (k >= 28) begin
                chk("steady_i", $signed(o_i), (k % 2 == 0) ? 62 : 59);
                chk("steady_q", $signed(o_q), (k % 2 == 0) ? 62 : 59);
                chk("steady_underrun", int'(o_underrun), 0);
            end
        end

        // Enable gating mid-stream
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 2'b11, 0, 0, 0);
            chk("gate_valid", int'(o_valid), 0);
            chk("gate_frozen_i", $signed(o_i), 59);
            chk("gate_frozen_phase", int'(o_phase), OS - 1);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 1, 2'b11, 0, 0, 0);
            chk("resume_i", $signed(o_i), (k % 2 == 0) ? 62 : 59);
        end

        // Underrun, then reset mid-stream at phase 2
        for (int k = 0; k < 4; k++) step(0, 1, 0, 2'b00, 0, 0, 0);
        chk("underrun_set", int'(o_underrun), 1);
        for (int k = 0; k < OS && m_phase != 2; k++) step(0, 1, 1, 2'b01, 0, 0, 0);
        step(1, 1, 1, 2'b11, 0, 0, 0);
        chk("midrst_o_i", $signed(o_i), 0);
        chk("midrst_o_q", $signed(o_q), 0);
        chk("midrst_o_phase", int'(o_phase), 0);
        chk("midrst_underrun", int'(o_underrun), 0);
        fill_table(2'b11, 0);
        run_table("post_reset_impulse");

        // Randomized stream against the model
        for (int k = 0; k < 400; k++) begin
            we = 0; wa = 0; wd = 0;
`ifdef QPSK_TX_COEF_LOAD_EN
            we = ($urandom_range(0, 19) == 0) ? 1 : 0;
            wa = int'($urandom_range(0, 31));
            wd = int'($urandom_range(0, 255)) - 128;
`endif
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), we[0], wa, wd);
        end

`ifdef QPSK_TX_COEF_LOAD_EN
        // Coefficient load with saturation (write during reset still lands)
        step(1, 0, 0, 2'b00, 1, 0, 127);
        for (int a = 1; a < TAPS; a++) step(0, 0, 0, 2'b00, 1, a, 127);
        step(0, 0, 0, 2'b00, 1, 30, -5);
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 1, 2'b11, 0, 0, 0);
            if (k >= 28) chk("coef_sat_pos", $signed(o_i), 127);
        end
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 1, 2'b00, 0, 0, 0);
            if (k >= 28) chk("coef_sat_neg", $signed(o_i), -128);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
